// File: rtl/serial_pkg.sv
// serial_pkg: constants and types shared by the serial receive path.
//   FRAME_BITS       - payload bits per frame (parity + 8 data bits)
//   BAUD_DIV_DEFAULT - default clocks per bit period
//   LINE_IDLE        - level of an idle serial line
//   CNT_W / IDX_W    - widths of the bit-period counter and bit index
//   rx_state_e       - receiver state encoding, also exported for debug
package serial_pkg;

  localparam int   FRAME_BITS       = 9;
  localparam int   BAUD_DIV_DEFAULT = 4;
  localparam logic LINE_IDLE        = 1'b1;
  localparam int   CNT_W            = 8;
  localparam int   IDX_W            = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

endpackage

// File: rtl/line_sync.sv
// line_sync: two-flop synchronizer for a single asynchronous input.
// Both flops reset to RESET_VAL so an idle-high line does not look like
// a falling edge right after reset.
//   clk_i   - destination clock
//   rst_i   - asynchronous active-high reset
//   async_i - asynchronous input
//   sync_o  - input re-timed to clk_i, 2 clocks of latency
module line_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/serial_line_receiver.sv
// serial_line_receiver: mid-bit-sampling receiver for 9-bit frames
// (start, parity, 8 data bits LSB first, stop) on an idle-high line.
//   clk            - clock, rising edge
//   rst            - asynchronous active-high reset
//   line           - serial input, asynchronous to clk
//   Ok             - consumer acknowledge (level sampled)
//   data_available - Data holds an unconsumed frame
//   Data           - frame; bit 0 = parity (first received), 8:1 = byte
//   frame_err      - 1-cycle pulse: stop bit sampled low
//   overrun        - 1-cycle pulse: frame completed while data_available high
//   busy           - receiver is not in IDLE
//   state_dbg      - current receiver state
//
// Handshake: data_available/Data form a valid/ready pair. data_available
// rises with Data already stable and stays high, Data unchanged, until an
// edge samples Ok=1; that edge consumes the frame. Ok while
// data_available is low does nothing, and on the edge that sets
// data_available the set wins over a simultaneous Ok.
module serial_line_receiver
  import serial_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  line,
  input  logic                  Ok,
  output logic                  data_available,
  output logic [FRAME_BITS-1:0] Data,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy,
  output rx_state_e             state_dbg
);

  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(BAUD_DIV / 2);
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(BAUD_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BITS - 1);

  logic line_s;

  rx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [FRAME_BITS-1:0] data_q, data_d;
  logic                  dav_q, dav_d;
  logic                  fe_q, fe_d;
  logic                  ov_q, ov_d;

  logic start_tick;
  logic bit_tick;

  line_sync #(.RESET_VAL(LINE_IDLE)) u_line_sync (
    .clk_i   (clk),
    .rst_i   (rst),
    .async_i (line),
    .sync_o  (line_s)
  );

  // START is loaded with HALF_BIT and samples on the edge where the
  // decrement reaches zero, so the start sample lands HALF_BIT clocks
  // after the low was seen. DATA/STOP count RELOAD..0 and sample while the
  // counter reads zero, which spaces samples exactly BAUD_DIV apart.
  assign start_tick = (state_q == ST_START) && (cnt_q == CNT_W'(1));
  assign bit_tick   = ((state_q == ST_DATA) || (state_q == ST_STOP)) &&
                      (cnt_q == '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      dav_q   <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      dav_q   <= dav_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (!line_s) state_d = ST_START;
      ST_START:     if (start_tick) state_d = line_s ? ST_IDLE : ST_DATA;
      ST_DATA:      if (bit_tick && (idx_q == LAST_IDX)) state_d = ST_STOP;
      ST_STOP:      if (bit_tick) state_d = line_s ? ST_IDLE : ST_WAIT_HIGH;
      // A held-low line (break) must go high before a new start is armed.
      ST_WAIT_HIGH: if (line_s) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Counter, shift register and output register updates
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    dav_d   = dav_q;
    fe_d    = 1'b0;
    ov_d    = 1'b0;

    // Consumer clear first; a frame completing on this edge overrides it.
    if (dav_q && Ok) dav_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!line_s) cnt_d = HALF_BIT;
      end
      ST_START: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (start_tick && !line_s) begin
          cnt_d = RELOAD;
          idx_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          shreg_d[idx_q] = line_s;
          cnt_d          = RELOAD;
          idx_d          = idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (!line_s) begin
            fe_d = 1'b1;
          end else if (dav_q) begin
            // Previous frame still unconsumed: keep it, drop this one.
            ov_d = 1'b1;
          end else begin
            data_d = shreg_q;
            dav_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    data_available = dav_q;
    Data           = data_q;
    frame_err      = fe_q;
    overrun        = ov_q;
    busy           = (state_q != ST_IDLE);
    state_dbg      = state_q;
  end

endmodule

// File: tb/tb_serial_line_receiver.sv
// tb_serial_line_receiver: self-checking bench for serial_line_receiver.
// Three instances (BAUD_DIV 4, 3, 16) share clock and reset; instance 0
// carries the directed, table-driven and randomized tests, the other two
// the divider sweep.
module tb_serial_line_receiver;
  import serial_pkg::*;

  localparam int NDUT = 3;
  localparam int DIV0 = 4;
  localparam int DIV1 = 3;
  localparam int DIV2 = 16;
  // Line change to the FSM acting on it: two sync flops plus the IDLE edge.
  localparam int SYNC_LAT = 3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- DUT instances ----------------
  logic      line_v [NDUT];
  logic      ok_v   [NDUT];
  logic      dav_v  [NDUT];
  logic [8:0] data_v [NDUT];
  logic      fe_v   [NDUT];
  logic      ov_v   [NDUT];
  logic      busy_v [NDUT];
  rx_state_e st_v   [NDUT];

  serial_line_receiver #(.BAUD_DIV(DIV0)) u_dut0 (
    .clk(clk), .rst(rst), .line(line_v[0]), .Ok(ok_v[0]),
    .data_available(dav_v[0]), .Data(data_v[0]), .frame_err(fe_v[0]),
    .overrun(ov_v[0]), .busy(busy_v[0]), .state_dbg(st_v[0]));

  serial_line_receiver #(.BAUD_DIV(DIV1)) u_dut1 (
    .clk(clk), .rst(rst), .line(line_v[1]), .Ok(ok_v[1]),
    .data_available(dav_v[1]), .Data(data_v[1]), .frame_err(fe_v[1]),
    .overrun(ov_v[1]), .busy(busy_v[1]), .state_dbg(st_v[1]));

  serial_line_receiver #(.BAUD_DIV(DIV2)) u_dut2 (
    .clk(clk), .rst(rst), .line(line_v[2]), .Ok(ok_v[2]),
    .data_available(dav_v[2]), .Data(data_v[2]), .frame_err(fe_v[2]),
    .overrun(ov_v[2]), .busy(busy_v[2]), .state_dbg(st_v[2]));

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;

  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  logic dav_prev [NDUT];
  logic fe_prev  [NDUT];
  logic ov_prev  [NDUT];
  int   rise_cyc [NDUT];
  int   fe_cyc   [NDUT];
  int   ov_cyc   [NDUT];
  int   fe_cnt   [NDUT];
  int   ov_cnt   [NDUT];
  int   wide_cnt = 0;
  int   both_cnt = 0;

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (dav_v[i] === 1'b1 && dav_prev[i] === 1'b0) begin
        rise_cyc[i] = cyc;
        if (i == 0) got_q.push_back(data_v[i]);
      end
      if (fe_v[i] === 1'b1) begin
        fe_cnt[i]++;
        fe_cyc[i] = cyc;
        if (fe_prev[i] === 1'b1) wide_cnt++;
      end
      if (ov_v[i] === 1'b1) begin
        ov_cnt[i]++;
        ov_cyc[i] = cyc;
        if (ov_prev[i] === 1'b1) wide_cnt++;
      end
      if (fe_v[i] === 1'b1 && ov_v[i] === 1'b1) both_cnt++;
      dav_prev[i] = dav_v[i];
      fe_prev[i]  = fe_v[i];
      ov_prev[i]  = ov_v[i];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the falling edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  function automatic int div_of(input int w);
    case (w)
      0:       return DIV0;
      1:       return DIV1;
      default: return DIV2;
    endcase
  endfunction

  // Start bit, payload bit 0 first, then the stop level for stop_periods bits.
  task automatic send_frame(input int w, input logic [8:0] payload,
                            input logic stop_v, input int stop_periods);
    int b;
    b = div_of(w);
    line_v[w] = 1'b0;
    tick(b);
    for (int i = 0; i < 9; i++) begin
      line_v[w] = payload[i];
      tick(b);
    end
    line_v[w] = stop_v;
    tick(b * stop_periods);
    line_v[w] = 1'b1;
  endtask

  // Start bit plus payload bits 0..nbits-1, then half of bit nbits.
  task automatic send_partial(input int w, input logic [8:0] payload, input int nbits);
    int b;
    b = div_of(w);
    line_v[w] = 1'b0;
    tick(b);
    for (int i = 0; i < nbits; i++) begin
      line_v[w] = payload[i];
      tick(b);
    end
    line_v[w] = payload[nbits];
    tick(b / 2);
  endtask

  task automatic wait_dav(input int w, input string name);
    int n;
    n = 0;
    while (dav_v[w] !== 1'b1 && n < 500) begin
      tick(1);
      n++;
    end
    if (dav_v[w] !== 1'b1) check({name, "_timeout"}, 32'(dav_v[w]), 32'd1);
  endtask

  task automatic ack(input int w, input string name);
    ok_v[w] = 1'b1;
    tick(1);
    ok_v[w] = 1'b0;
    check({name, "_ack_clear"}, 32'(dav_v[w]), 32'd0);
  endtask

  function automatic int frame_latency(input int b);
    return SYNC_LAT + 10 * b + b / 2;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] dbyte;
    logic       par;
    logic [8:0] exp_data;
  } vec_t;

  vec_t tbl [6];

  // ---------------- test sequence ----------------
  initial begin
    int k, k2, fe_base, ov_base, fe_exp, ov_exp;
    logic pending;
    logic [7:0] rb;
    logic rp, bad;
    logic [8:0] e, g;

    tbl[0] = '{8'hA5, 1'b0, 9'h14A};
    tbl[1] = '{8'h3C, 1'b1, 9'h079};
    tbl[2] = '{8'h00, 1'b1, 9'h001};
    tbl[3] = '{8'hFF, 1'b1, 9'h1FF};
    tbl[4] = '{8'h80, 1'b0, 9'h100};
    tbl[5] = '{8'h01, 1'b0, 9'h002};

    rst = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      line_v[i]   = 1'b1;
      ok_v[i]     = 1'b0;
      dav_prev[i] = 1'b0;
      fe_prev[i]  = 1'b0;
      ov_prev[i]  = 1'b0;
    end

    // Reset state
    tick(3);
    check("rst_dav", 32'(dav_v[0]), 32'd0);
    check("rst_data", 32'(data_v[0]), 32'h000);
    check("rst_busy", 32'(busy_v[0]), 32'd0);
    rst = 1'b0;
    tick(3);
    check("post_rst_state", 32'(st_v[0]), 32'(ST_IDLE));
    check("post_rst_fe", 32'(fe_v[0]), 32'd0);
    check("post_rst_ov", 32'(ov_v[0]), 32'd0);

    // Ok with nothing pending has no effect
    ack(0, "idle_ok");

    // Table-driven normal frames on BAUD_DIV=4
    foreach (tbl[i]) begin
      k = cyc;
      send_frame(0, {tbl[i].dbyte, tbl[i].par}, 1'b1, 1);
      wait_dav(0, "tbl");
      check($sformatf("tbl%0d_data", i), 32'(data_v[0]), 32'(tbl[i].exp_data));
      check($sformatf("tbl%0d_lat", i), 32'(rise_cyc[0] - k), 32'(frame_latency(DIV0)));
      ack(0, $sformatf("tbl%0d", i));
      tick(2);
    end

    // Ok held high across the setting edge: the set wins
    ok_v[0] = 1'b1;
    send_frame(0, {8'h5A, 1'b1}, 1'b1, 1);
    wait_dav(0, "same_edge");
    ok_v[0] = 1'b0;
    tick(1);
    check("same_edge_dav", 32'(dav_v[0]), 32'd1);
    check("same_edge_data", 32'(data_v[0]), 32'h0B5);
    ack(0, "same_edge");
    tick(2);

    // False start: one-clock glitch
    fe_base = fe_cnt[0];
    ov_base = ov_cnt[0];
    line_v[0] = 1'b0;
    tick(1);
    line_v[0] = 1'b1;
    tick(2);
    check("glitch_busy_hi", 32'(busy_v[0]), 32'd1);
    tick(3);
    check("glitch_busy_lo", 32'(busy_v[0]), 32'd0);
    tick(20);
    check("glitch_dav", 32'(dav_v[0]), 32'd0);
    check("glitch_flags", 32'(fe_cnt[0] - fe_base + ov_cnt[0] - ov_base), 32'd0);

    // Framing error: stop held low for 3 bit periods
    fe_base = fe_cnt[0];
    ov_base = ov_cnt[0];
    k = cyc;
    send_frame(0, {8'h3C, 1'b0}, 1'b0, 3);
    check("fe_wait_state", 32'(st_v[0]), 32'(ST_WAIT_HIGH));
    check("fe_pulses", 32'(fe_cnt[0] - fe_base), 32'd1);
    check("fe_when", 32'(fe_cyc[0] - k), 32'(frame_latency(DIV0)));
    tick(8);
    check("fe_idle_again", 32'(st_v[0]), 32'(ST_IDLE));
    tick(60);
    check("fe_no_frame", 32'(dav_v[0]), 32'd0);
    check("fe_data_kept", 32'(data_v[0]), 32'h0B5);
    check("fe_single", 32'(fe_cnt[0] - fe_base), 32'd1);
    check("fe_no_ov", 32'(ov_cnt[0] - ov_base), 32'd0);

    // Overrun: two back-to-back frames, Ok held low
    fe_base = fe_cnt[0];
    ov_base = ov_cnt[0];
    send_frame(0, {8'h11, 1'b0}, 1'b1, 1);
    k2 = cyc;
    send_frame(0, {8'h22, 1'b0}, 1'b1, 1);
    tick(4);
    check("ov_pulses", 32'(ov_cnt[0] - ov_base), 32'd1);
    check("ov_when", 32'(ov_cyc[0] - k2), 32'(frame_latency(DIV0)));
    check("ov_data", 32'(data_v[0]), 32'h022);
    check("ov_dav", 32'(dav_v[0]), 32'd1);
    check("ov_no_fe", 32'(fe_cnt[0] - fe_base), 32'd0);

    // Reset during data bit 4 of 0xFF (frame 0x022 still pending)
    send_partial(0, {8'hFF, 1'b0}, 5);
    check("pre_rst_busy", 32'(busy_v[0]), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_dav", 32'(dav_v[0]), 32'd0);
    check("mid_rst_data", 32'(data_v[0]), 32'h000);
    check("mid_rst_busy", 32'(busy_v[0]), 32'd0);
    check("mid_rst_flags", 32'({fe_v[0], ov_v[0]}), 32'd0);
    check("mid_rst_state", 32'(st_v[0]), 32'(ST_IDLE));
    line_v[0] = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(20);
    check("post_mid_rst_dav", 32'(dav_v[0]), 32'd0);
    k = cyc;
    send_frame(0, {8'h55, 1'b0}, 1'b1, 1);
    wait_dav(0, "after_rst");
    check("after_rst_data", 32'(data_v[0]), 32'h0AA);
    check("after_rst_lat", 32'(rise_cyc[0] - k), 32'(frame_latency(DIV0)));
    ack(0, "after_rst");

    // Divider sweep: BAUD_DIV 3 and 16
    for (int w = 1; w < NDUT; w++) begin
      tick(3);
      k = cyc;
      send_frame(w, {8'hA5, 1'b0}, 1'b1, 1);
      wait_dav(w, "sweep");
      check($sformatf("sweep_div%0d_data", div_of(w)), 32'(data_v[w]), 32'h14A);
      check($sformatf("sweep_div%0d_lat", div_of(w)), 32'(rise_cyc[w] - k),
            32'(frame_latency(div_of(w))));
      ack(w, "sweep");
    end

    // Randomized frames against a frame-level model
    tick(4);
    got_q.delete();
    exp_q.delete();
    pending = 1'b0;
    fe_exp  = fe_cnt[0];
    ov_exp  = ov_cnt[0];
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        ok_v[0] = 1'b1;
        tick(1);
        ok_v[0] = 1'b0;
        pending = 1'b0;
      end
      tick(DIV0 * int'($urandom_range(0, 2)));
      rb  = 8'($urandom_range(0, 255));
      rp  = 1'($urandom_range(0, 1));
      bad = ($urandom_range(0, 5) == 0);
      send_frame(0, {rb, rp}, ~bad, 1);
      if (bad) begin
        fe_exp++;
      end else if (pending) begin
        ov_exp++;
      end else begin
        exp_q.push_back({rb, rp});
        pending = 1'b1;
      end
      tick(6);
      check("rand_dav", 32'(dav_v[0]), 32'(pending));
      check("rand_frames", 32'(got_q.size()), 32'(exp_q.size()));
      while (got_q.size() > 0 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = got_q.pop_front();
        check("rand_data", 32'(g), 32'(e));
      end
    end
    check("rand_fe_total", 32'(fe_cnt[0]), 32'(fe_exp));
    check("rand_ov_total", 32'(ov_cnt[0]), 32'(ov_exp));

    // Flag shape over the whole run
    check("flag_width", 32'(wide_cnt), 32'd0);
    check("flag_exclusive", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_line_receiver.md
# serial_line_receiver

Mid-bit-sampling serial receiver that recovers 9-bit frames (8 data bits plus 1 parity bit) from the serial `line`. It sits directly upstream of the parity checker and presents each frame on the same `data_available` / `Ok` handshake that the checker already consumes. The block adds three things to the receive path: a line synchronizer, false-start rejection, and framing/overrun detection.

## Interface
- `BAUD_DIV`, 4: clocks per bit period; legal range 3–255.
- `FRAME_BITS`, 9: payload bits per frame. Fixed at 9; not user-tunable.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `line` input 1: serial input, idle high, asynchronous to `clk`.
- `Ok` input 1: consumer acknowledge; level-sampled.
- `data_available` output 1: `Data` holds an unconsumed frame.
- `Data` output 9: received frame; bit 0 is the first bit received (parity), bits 8:1 are the byte, LSB first.
- `frame_err` output 1: one-cycle pulse when the stop bit samples low.
- `overrun` output 1: one-cycle pulse when a frame completes while `data_available` is still high.
- `busy` output 1: high in every state except IDLE.

## Operation
- **Synchronizer:** two-flop synchronizer on `line` produces `line_s`. Both flops reset to 1.
- **IDLE:** when `line_s` is 0, load the bit counter with `BAUD_DIV/2` (floor) and go to START.
- **START:** decrement the counter. When it reaches 0, sample `line_s`.
  - If 1: false start; return to IDLE and raise no flags.
  - If 0: reload the counter with `BAUD_DIV-1`, clear the bit index, go to DATA.
- **DATA:** each time the counter reaches 0, shift `line_s` into the shift register at position `bit_idx` and reload `BAUD_DIV-1`. After bit index 8, go to STOP.
- **STOP:** when the counter reaches 0, sample `line_s`.
  - **Stop = 1, `data_available` = 0:** load `Data` from the shift register, set `data_available`, go to IDLE.
  - **Stop = 1, `data_available` = 1:** pulse `overrun`, discard the new frame, leave `Data` unchanged, go to IDLE.
  - **Stop = 0:** pulse `frame_err`, discard the frame, go to WAIT_HIGH.
- **WAIT_HIGH:** stay until `line_s` is 1, then go to IDLE. This stops a break condition from being re-read as a new start bit.
- **Handshake:**
  - `data_available` clears on the first clock edge where `Ok` = 1.
  - `Ok` has no effect while `data_available` = 0.
  - `Ok` is ignored on the same edge that sets `data_available`; the set wins.
- **Counter width:** 8 bits; bit index 4 bits. No wrap is possible within legal `BAUD_DIV`.
- **Reset values:**
  - State = IDLE, shift register = 0.
  - `Data` = 9'h000, `data_available` = 0, `frame_err` = 0, `overrun` = 0, `busy` = 0.
- **Reset mid-frame:** abandons the frame immediately. After release the block re-synchronizes on the next falling edge of `line` only; it does not resume the abandoned frame.

## Timing
- **Synchronizer latency:** 2 clocks from `line` to `line_s`.
- **Start sample:** taken `BAUD_DIV/2` clocks after the first low `line_s`. Each subsequent sample follows `BAUD_DIV` clocks after the previous one.
- **Frame to output:** `data_available` rises on the edge of the stop-bit sample, 10·`BAUD_DIV` + `BAUD_DIV/2` clocks after the first low `line_s`.
- **Back-to-back frames:** IDLE is re-entered on the stop-sample edge, so the next start edge can arrive half a bit later.
- **Bit spacing:** the upstream transmitter's 2 idle bits between frames are tolerated but not required.
- **`Ok` to clear:** `data_available` falls 1 clock after `Ok` is sampled high.
- **Flags:** `frame_err` and `overrun` are registered, exactly 1 clock wide, and never asserted in the same cycle.

## Structure
- **Shared package `serial_pkg`:** state encoding (IDLE, START, DATA, STOP, WAIT_HIGH), `FRAME_BITS` = 9, default `BAUD_DIV`, and the idle line level.
- **Sub-module `line_sync`:** the reset-to-1 two-flop synchronizer. It will also be reused on other asynchronous inputs.
- **Top:** state machine, counter, shift register and output registers all live in the top module.

## Test plan
- **Normal frame:** `BAUD_DIV`=4; send byte 0xA5 with parity 0 (line: start, 0,1,0,1,0,0,1,0,1, stop). Expect `Data`=9'h14A and `data_available`=1; after `Ok` pulsed for 1 cycle, `data_available`=0 on the next edge.
- **False start:** 1-clock low glitch on `line`, then high. Expect `busy` to return to 0 within 3 clocks, `data_available` to stay 0, and no flags.
- **Framing error:** send byte 0x3C with the stop bit held low for 3 bit periods. Expect `frame_err` as a single 1-cycle pulse, `Data` unchanged, and the state to stay WAIT_HIGH until the line goes high; no spurious frame follows.
- **Overrun:** send 0x11 then 0x22 back-to-back with `Ok` held 0. Expect `Data`=9'h022 (0x11 with parity 0), an `overrun` pulse at the second stop sample, and `Data` still 9'h022.
- **Reset mid-frame:** assert `rst` during data bit 4 of 0xFF. Expect all outputs at reset values immediately; a following 0x55 is received correctly as 9'h0AA.
- **Divider sweep:** repeat the normal-frame case with `BAUD_DIV`=3 and `BAUD_DIV`=16. Expect identical `Data`, with `data_available` latency matching the formula in Timing.
